rsa_exp_sched: RTL and testbench

Modular-exponentiation scheduler for the RSA core: computes o_a_pow_e = i_a^i_e mod i_n by sequencing one external Montgomery-transform unit (montTrans) and one shared external Montgomery-product unit, doing right-to-left binary exponentiation. It holds no wide arithmetic, only operand/result registers, a bit counter and the handshake FSM. The parent rsa_core instantiates this block beside the two datapath units.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_exp_sched.sv | 204 ++++++++++++++++++++
 tb/tb_rsa_exp_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA core: key width, exponent-bit index width,
// the exponentiation scheduler state type and a small exponent helper.
package rsa_pkg;

  localparam int KEY_W = 256;
  localparam int IDX_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRANS,
    S_MUL,
    S_SQR,
    S_DONE
  } state_t;

  // True when no exponent bit above position j is set.
  function automatic logic bits_above_zero(input logic [KEY_W-1:0] e,
                                           input logic [IDX_W-1:0] j);
    return ((e >> j) >> 1) == '0;
  endfunction

endpackage

// File: rtl/rsa_exp_sched.sv
// rsa_exp_sched: right-to-left binary modular exponentiation scheduler.
// Sequences one montTrans request (t = a*R mod n) and then, per exponent
// bit, an optional multiply MP(m,t) and a square MP(t,t). m stays in plain
// form, so the final m is a^e mod n without an inverse transform.
// Optional feature: define RSA_EXP_EARLY_EXIT_EN to stop as soon as no
// exponent bits remain above the current one.
module rsa_exp_sched
  import rsa_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_a,
  input  logic [KEY_W-1:0] i_e,
  input  logic [KEY_W:0]   i_n,
  output logic [KEY_W-1:0] o_a_pow_e,
  output logic             o_finished,
  output logic             o_trans_start,
  output logic [KEY_W-1:0] o_trans_a,
  output logic [KEY_W:0]   o_trans_n,
  input  logic [KEY_W-1:0] i_trans_result,
  input  logic             i_trans_finished,
  output logic             o_mp_start,
  output logic [KEY_W-1:0] o_mp_a,
  output logic [KEY_W-1:0] o_mp_b,
  output logic [KEY_W:0]   o_mp_n,
  input  logic [KEY_W-1:0] i_mp_result,
  input  logic             i_mp_finished
);

`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  // State and wait substate (0: start issued this cycle, 1: waiting on unit)
  state_t             r_state, w_state_nxt;
  logic               r_wait, w_wait_nxt;
  // Operands, plain-form accumulator m, Montgomery-form power t, bit index
  logic [KEY_W-1:0]   r_a, w_a_nxt;
  logic [KEY_W-1:0]   r_e, w_e_nxt;
  logic [KEY_W:0]     r_n, w_n_nxt;
  logic [KEY_W-1:0]   r_m, w_m_nxt;
  logic [KEY_W-1:0]   r_t, w_t_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  // Registered outputs
  logic               r_trans_start, w_trans_start_nxt;
  logic               r_mp_start, w_mp_start_nxt;
  logic [KEY_W-1:0]   r_mp_a, w_mp_a_nxt;
  logic [KEY_W-1:0]   r_mp_b, w_mp_b_nxt;
  logic               r_finished, w_finished_nxt;
  logic [KEY_W-1:0]   r_result, w_result_nxt;
  // Routing decisions taken on a captured result
  logic               w_route, w_go_mul, w_go_sqr, w_go_done;
  logic [IDX_W-1:0]   w_next_idx;

  // Next-state, operand capture and request issue
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_state_nxt       = r_state;
    w_wait_nxt        = r_wait;
    w_a_nxt           = r_a;
    w_e_nxt           = r_e;
    w_n_nxt           = r_n;
    w_m_nxt           = r_m;
    w_t_nxt           = r_t;
    w_idx_nxt         = r_idx;
    w_trans_start_nxt = 1'b0;
    w_mp_start_nxt    = 1'b0;
    w_mp_a_nxt        = r_mp_a;
    w_mp_b_nxt        = r_mp_b;
    w_finished_nxt    = 1'b0;
    w_result_nxt      = r_result;
    w_route           = 1'b0;
    w_go_mul          = 1'b0;
    w_go_sqr          = 1'b0;
    w_go_done         = 1'b0;
    w_next_idx        = '0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt       = S_TRANS;
          w_wait_nxt        = 1'b0;
          w_a_nxt           = i_a;
          w_e_nxt           = i_e;
          w_n_nxt           = i_n;
          w_m_nxt           = KEY_W'(1);
          w_idx_nxt         = '0;
          w_trans_start_nxt = 1'b1;
        end
      end
      S_TRANS: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else if (i_trans_finished) begin
          w_t_nxt    = i_trans_result;
          w_route    = 1'b1;
          w_next_idx = '0;
        end
      end
      S_MUL: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else if (i_mp_finished) begin
          w_m_nxt = i_mp_result;
          if (EARLY_EXIT && bits_above_zero(r_e, r_idx)) w_go_done = 1'b1;
          else                                           w_go_sqr  = 1'b1;
        end
      end
      S_SQR: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
        end else if (i_mp_finished) begin
          w_t_nxt = i_mp_result;
          if (r_idx == IDX_W'(KEY_W - 1)) begin
            w_go_done = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_next_idx = r_idx + IDX_W'(1);
            w_route    = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A zero exponent bit costs no cycles: go straight to its square.
    if (w_route) begin
      if (r_e[w_next_idx])                                   w_go_mul  = 1'b1;
      else if (EARLY_EXIT && bits_above_zero(r_e, w_next_idx)) w_go_done = 1'b1;
      else                                                   w_go_sqr  = 1'b1;
    end

    if (w_go_mul) begin
      w_state_nxt    = S_MUL;
      w_wait_nxt     = 1'b0;
      w_mp_start_nxt = 1'b1;
      w_mp_a_nxt     = w_m_nxt;
      w_mp_b_nxt     = w_t_nxt;
    end
    if (w_go_sqr) begin
      w_state_nxt    = S_SQR;
      w_wait_nxt     = 1'b0;
      w_mp_start_nxt = 1'b1;
      w_mp_a_nxt     = w_t_nxt;
      w_mp_b_nxt     = w_t_nxt;
    end
    if (w_go_done) begin
      w_state_nxt    = S_DONE;
      w_finished_nxt = 1'b1;
      w_result_nxt   = w_m_nxt;
    end
  end

  // State and operand registers; everything clears so outputs read 0 in reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wait        <= 1'b0;
      r_a           <= '0;
      r_e           <= '0;
      r_n           <= '0;
      r_m           <= '0;
      r_t           <= '0;
      r_idx         <= '0;
      r_trans_start <= 1'b0;
      r_mp_start    <= 1'b0;
      r_mp_a        <= '0;
      r_mp_b        <= '0;
      r_finished    <= 1'b0;
      r_result      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state       <= w_state_nxt;
      r_wait        <= w_wait_nxt;
      r_a           <= w_a_nxt;
      r_e           <= w_e_nxt;
      r_n           <= w_n_nxt;
      r_m           <= w_m_nxt;
      r_t           <= w_t_nxt;
      r_idx         <= w_idx_nxt;
      r_trans_start <= w_trans_start_nxt;
      r_mp_start    <= w_mp_start_nxt;
      r_mp_a        <= w_mp_a_nxt;
      r_mp_b        <= w_mp_b_nxt;
      r_finished    <= w_finished_nxt;
      r_result      <= w_result_nxt;
    end
  end

  assign o_a_pow_e     = r_result;
  assign o_finished    = r_finished;
  assign o_trans_start = r_trans_start;
  assign o_trans_a     = r_a;
  assign o_trans_n     = r_n;
  assign o_mp_start    = r_mp_start;
  assign o_mp_a        = r_mp_a;
  assign o_mp_b        = r_mp_b;
  assign o_mp_n        = r_n;

endmodule

// File: tb/tb_rsa_exp_sched.sv
// Bench for rsa_exp_sched: behavioural montTrans / Montgomery-product models
// with configurable or random latency, and a plain square-and-multiply
// reference for a^e mod n. Honours RSA_EXP_EARLY_EXIT_EN for request counts.
module tb_rsa_exp_sched;
  import rsa_pkg::*;

`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk, rst, start;
  logic [KEY_W-1:0] a, e;
  logic [KEY_W:0]   n;
  logic [KEY_W-1:0] o_a_pow_e, o_trans_a, o_mp_a, o_mp_b;
  logic [KEY_W:0]   o_trans_n, o_mp_n;
  logic             o_finished, o_trans_start, o_mp_start;
  logic             trans_fin_m, mp_fin_m, trans_fin_s, mp_fin_s;
  logic [KEY_W-1:0] trans_res_m, mp_res_m, spur_res;
  logic             trans_finished, mp_finished;
  logic [KEY_W-1:0] trans_result, mp_result;

  assign trans_finished = trans_fin_m | trans_fin_s;
  assign trans_result   = trans_fin_s ? spur_res : trans_res_m;
  assign mp_finished    = mp_fin_m | mp_fin_s;
  assign mp_result      = mp_fin_s ? spur_res : mp_res_m;

  rsa_exp_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_a(a), .i_e(e), .i_n(n),
    .o_a_pow_e(o_a_pow_e), .o_finished(o_finished),
    .o_trans_start(o_trans_start), .o_trans_a(o_trans_a), .o_trans_n(o_trans_n),
    .i_trans_result(trans_result), .i_trans_finished(trans_finished),
    .o_mp_start(o_mp_start), .o_mp_a(o_mp_a), .o_mp_b(o_mp_b), .o_mp_n(o_mp_n),
    .i_mp_result(mp_result), .i_mp_finished(mp_finished)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int lt_cfg = 1, lm_cfg = 1;  // 0 selects random latency 1..4
  int trans_starts = 0, mp_starts = 0, fin_pulses = 0, viol = 0;
  int start_cyc = 0;

  // ---------------- reference arithmetic ----------------
  function automatic logic [KEY_W-1:0] mulmod(input logic [KEY_W-1:0] x, y,
                                              input logic [KEY_W:0] nn);
    logic [512:0] p;
    p = 513'(x) * 513'(y);
    p = p % 513'(nn);
    return p[KEY_W-1:0];
  endfunction

  function automatic logic [KEY_W-1:0] mont_to(input logic [KEY_W-1:0] x,
                                               input logic [KEY_W:0] nn);
    logic [512:0] v;
    v = {1'b0, x, 256'b0};
    v = v % 513'(nn);
    return v[KEY_W-1:0];
  endfunction

  // x*y*2^-256 mod n: reduce, then halve modulo n 256 times.
  function automatic logic [KEY_W-1:0] mont_mul(input logic [KEY_W-1:0] x, y,
                                                input logic [KEY_W:0] nn);
    logic [KEY_W+1:0] acc;
    acc = 258'(mulmod(x, y, nn));
    for (int i = 0; i < KEY_W; i++) begin
      if (acc[0]) acc = acc + 258'(nn);
      acc = acc >> 1;
    end
    return acc[KEY_W-1:0];
  endfunction

  function automatic logic [KEY_W-1:0] modexp(input logic [KEY_W-1:0] x, ex,
                                              input logic [KEY_W:0] nn);
    logic [KEY_W-1:0] r, b;
    r = KEY_W'(1);
    b = x;
    for (int i = 0; i < KEY_W; i++) begin
      if (ex[i]) r = mulmod(r, b, nn);
      b = mulmod(b, b, nn);
    end
    return r;
  endfunction

  function automatic int exp_requests(input logic [KEY_W-1:0] ex);
    int sq;
    sq = KEY_W;
    if (EARLY) begin
      sq = 0;
      for (int i = KEY_W - 1; i >= 0; i--)
        if (ex[i]) begin sq = i; break; end
    end
    return $countones(ex) + sq;
  endfunction

  function automatic logic [KEY_W-1:0] rand256();
    logic [KEY_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- external unit models ----------------
  initial begin
    logic [KEY_W-1:0] r;
    int lat;
    trans_fin_m = 1'b0; trans_res_m = '0;
    forever begin
      @(negedge clk);
      if (o_trans_start && !rst) begin
        r   = mont_to(o_trans_a, o_trans_n);
        lat = (lt_cfg != 0) ? lt_cfg : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1 trans_res_m = r; trans_fin_m = 1'b1;
        @(posedge clk);
        #1 trans_fin_m = 1'b0;
      end
    end
  end

  initial begin
    logic [KEY_W-1:0] r;
    int lat;
    mp_fin_m = 1'b0; mp_res_m = '0;
    forever begin
      @(negedge clk);
      if (o_mp_start && !rst) begin
        r   = mont_mul(o_mp_a, o_mp_b, o_mp_n);
        lat = (lm_cfg != 0) ? lm_cfg : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1 mp_res_m = r; mp_fin_m = 1'b1;
        @(posedge clk);
        #1 mp_fin_m = 1'b0;
      end
    end
  end

  // Protocol monitor: one request outstanding, single-cycle done pulse
  initial begin
    int  outstanding;
    bit  prev_fin;
    outstanding = 0; prev_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0; prev_fin = 1'b0;
      end else begin
        if (o_trans_start) trans_starts++;
        if (o_mp_start)    mp_starts++;
        if (o_trans_start || o_mp_start) begin
          if (outstanding != 0 || (o_trans_start && o_mp_start)) viol++;
          outstanding++;
        end
        if (trans_fin_m || mp_fin_m) outstanding--;
        if (o_finished) begin
          fin_pulses++;
          if (prev_fin) viol++;
        end
        prev_fin = o_finished;
      end
    end
  end

  // ---------------- check and stimulus helpers ----------------
  task automatic chk(input string tag, input logic [KEY_W:0] obs, input logic [KEY_W:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [KEY_W-1:0] xa, xe, input logic [KEY_W:0] xn);
    @(negedge clk);
    a = xa; e = xe; n = xn; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("trans_start_cycle1", 257'(o_trans_start), 257'(1));
  endtask

  task automatic wait_done(input int budget, output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_finished) begin
        ok = 1'b1;
        lat = cyc - start_cyc + 1;
        break;
      end
    end
  endtask

  task automatic wait_mp_start(input int k, output bit ok);
    int seen;
    seen = 0; ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (o_mp_start) seen++;
      if (seen == k) begin ok = 1'b1; break; end
    end
  endtask

  task automatic recover();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_full(input string tag, input logic [KEY_W-1:0] xa, xe,
                          input logic [KEY_W:0] xn, input logic [KEY_W-1:0] expv,
                          input bit fixed_lat);
    int mp0, tr0, fn0, vi0, lat, reqs;
    bit ok;
    mp0 = mp_starts; tr0 = trans_starts; fn0 = fin_pulses; vi0 = viol;
    reqs = exp_requests(xe);
    launch(xa, xe, xn);
    wait_done(6000, ok, lat);
    chk({tag, "_done"}, 257'(ok), 257'(1));
    if (!ok) begin
      recover();
      return;
    end
    chk({tag, "_result"}, 257'(o_a_pow_e), 257'(expv));
    repeat (3) @(negedge clk);
    chk({tag, "_mp_reqs"}, 257'(mp_starts - mp0), 257'(reqs));
    chk({tag, "_trans_reqs"}, 257'(trans_starts - tr0), 257'(1));
    chk({tag, "_fin_pulses"}, 257'(fin_pulses - fn0), 257'(1));
    chk({tag, "_protocol"}, 257'(viol - vi0), 257'(0));
    if (fixed_lat)
      chk({tag, "_latency"}, 257'(lat), 257'(3 + lt_cfg + reqs * (1 + lm_cfg)));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ok;
    int lat, mp0, tr0, fn0, vi0;
    logic [KEY_W-1:0] ra, re;
    logic [KEY_W:0]   rn;

    rst = 1'b1; start = 1'b0; a = '0; e = '0; n = '0;
    trans_fin_s = 1'b0; mp_fin_s = 1'b0; spur_res = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", 257'(o_a_pow_e), 257'(0));
    chk("reset_outputs", 257'(|{o_finished, o_trans_start, o_mp_start, o_trans_a,
                               o_trans_n, o_mp_a, o_mp_b, o_mp_n}), 257'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors with fixed unit latencies
    lt_cfg = 1; lm_cfg = 1;
    run_full("a4_e13", 256'd4, 256'd13, 257'd77, 256'd53, 1'b1);
    lt_cfg = 2; lm_cfg = 3;
    run_full("a5_e1", 256'd5, 256'd1, 257'd77, 256'd5, 1'b1);
    run_full("a9_e0", 256'd9, 256'd0, 257'd77, 256'd1, 1'b1);
    repeat (5) @(negedge clk);
    chk("result_held", 257'(o_a_pow_e), 257'(1));

    // Start pulsed while squaring is ignored
    lt_cfg = 2; lm_cfg = 4;
    tr0 = trans_starts; fn0 = fin_pulses; vi0 = viol; mp0 = mp_starts;
    launch(256'd4, 256'd13, 257'd77);
    wait_mp_start(2, ok);
    chk("busy_wait_sqr", 257'(ok), 257'(1));
    a = 256'd5; e = 256'd3; n = 257'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6000, ok, lat);
    chk("busy_done", 257'(ok), 257'(1));
    chk("busy_result", 257'(o_a_pow_e), 257'(53));
    repeat (3) @(negedge clk);
    chk("busy_trans_reqs", 257'(trans_starts - tr0), 257'(1));
    chk("busy_mp_reqs", 257'(mp_starts - mp0), 257'(exp_requests(256'd13)));
    chk("busy_fin_pulses", 257'(fin_pulses - fn0), 257'(1));
    chk("busy_protocol", 257'(viol - vi0), 257'(0));
    run_full("after_busy", 256'd5, 256'd3, 257'd77, 256'd48, 1'b1);

    // Spurious finished pulses from the unit not being waited on
    lt_cfg = 4; lm_cfg = 3;
    mp0 = mp_starts; fn0 = fin_pulses;
    launch(256'd4, 256'd13, 257'd77);
    @(negedge clk);
    spur_res = rand256(); mp_fin_s = 1'b1;
    @(negedge clk);
    mp_fin_s = 1'b0;
    wait_mp_start(2, ok);
    chk("spur_wait_sqr", 257'(ok), 257'(1));
    @(negedge clk);
    spur_res = rand256(); trans_fin_s = 1'b1;
    @(negedge clk);
    trans_fin_s = 1'b0;
    wait_done(6000, ok, lat);
    chk("spur_done", 257'(ok), 257'(1));
    chk("spur_result", 257'(o_a_pow_e), 257'(53));
    chk("spur_latency", 257'(lat), 257'(3 + 4 + exp_requests(256'd13) * 4));
    repeat (3) @(negedge clk);
    chk("spur_mp_reqs", 257'(mp_starts - mp0), 257'(exp_requests(256'd13)));

    // Reset while a multiply is outstanding
    lt_cfg = 1; lm_cfg = 4;
    fn0 = fin_pulses;
    launch(256'd7, 256'd11, 257'd77);
    wait_mp_start(1, ok);
    chk("rst_wait_mul", 257'(ok), 257'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 257'(|{o_a_pow_e, o_finished, o_trans_start, o_mp_start,
                                 o_trans_a, o_trans_n, o_mp_a, o_mp_b, o_mp_n}), 257'(0));
    repeat (10) @(negedge clk);
    rst = 1'b0;
    chk("rst_no_finish", 257'(fin_pulses - fn0), 257'(0));
    run_full("after_rst", 256'd9, 256'd200, 257'd77,
             modexp(256'd9, 256'd200, 257'd77), 1'b1);

    // Random full-width vectors with random unit latencies
    lt_cfg = 0; lm_cfg = 0;
    for (int v = 0; v < 16; v++) begin
      rn = {1'b0, rand256()};
      rn[0] = 1'b1;
      if (rn < 257'd3) rn = 257'd3;
      ra = 256'(257'(rand256()) % rn);
      re = rand256();
      if (v == 0) re = 256'd0;
      if (v == 1) re = 256'hFFFF;
      run_full($sformatf("rand%0d", v), ra, re, rn, modexp(ra, re, rn), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
